// File: rtl/univ_shift_reg.sv
// Universal shift register: hold / shift left / shift right / parallel load, with frame counter.
// Latency: one clock for every mode; all outputs are registered, no input-to-output paths.
// Backpressure: none; no handshake, so the caller sequences mode/din/p_din every cycle.
//
// Ports:
//   clk, rst_n      rising-edge clock, synchronous active-low reset
//   mode[1:0]       00 hold, 01 shift left, 10 shift right, 11 parallel load
//   din             serial input bit
//   rot             rotate request (only honoured when USR_ROTATE_EN is defined)
//   p_din           parallel load data
//   p_dout          register contents
//   s_dout          registered copy of the bit shifted out on the last shift
//   bit_cnt         shifts since last load / reset / frame wrap (0..WIDTH-1)
//   frame_done      one-cycle pulse when the WIDTH-th shift of a frame lands
//
// Build option: define USR_ROTATE_EN to feed the outgoing bit back in when rot=1.
// Without it the rot port is present but unused and no rotate muxing exists.

module univ_shift_reg #(
    parameter int                 WIDTH     = 8,
    parameter logic [WIDTH-1:0]   RESET_VAL = '0
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [1:0]                 mode,
    input  logic                       din,
    input  logic                       rot,
    input  logic [WIDTH-1:0]           p_din,
    output logic [WIDTH-1:0]           p_dout,
    output logic                       s_dout,
    output logic [$clog2(WIDTH):0]     bit_cnt,
    output logic                       frame_done
);

    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        MODE_HOLD  = 2'b00,
        MODE_SHL   = 2'b01,
        MODE_SHR   = 2'b10,
        MODE_LOAD  = 2'b11
    } mode_e;

    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic             sout_q,  sout_d;
    logic [CW-1:0]    cnt_q,   cnt_d;
    logic             fdone_q, fdone_d;

    // Bit entering the register on a shift, one per direction.
    logic in_bit_l;
    logic in_bit_r;

`ifdef USR_ROTATE_EN
    // Rotate recirculates the bit that is leaving on this same edge.
    assign in_bit_l = rot ? shreg_q[WIDTH-1] : din;
    assign in_bit_r = rot ? shreg_q[0]       : din;
`else
    logic unused_rot;
    assign unused_rot = rot;
    assign in_bit_l   = din;
    assign in_bit_r   = din;
`endif

    // Frame counter step shared by both shift directions. Direction changes
    // mid-frame keep counting; only load, reset or wrap clear the count.
    logic          cnt_wrap;
    logic [CW-1:0] cnt_next;
    logic          fdone_next;

    always_comb begin
        cnt_wrap   = (cnt_q == CW'(WIDTH - 1));
        cnt_next   = cnt_wrap ? '0 : cnt_q + CW'(1);
        fdone_next = cnt_wrap;
    end

    always_comb begin
        shreg_d = shreg_q;
        sout_d  = sout_q;
        cnt_d   = cnt_q;
        fdone_d = 1'b0;   // pulse only: low on any edge that is not a wrapping shift
        case (mode_e'(mode))
            MODE_HOLD: begin
                // everything keeps its value, frame_done drops
            end
            MODE_SHL: begin
                shreg_d = {shreg_q[WIDTH-2:0], in_bit_l};
                sout_d  = shreg_q[WIDTH-1];
                cnt_d   = cnt_next;
                fdone_d = fdone_next;
            end
            MODE_SHR: begin
                shreg_d = {in_bit_r, shreg_q[WIDTH-1:1]};
                sout_d  = shreg_q[0];
                cnt_d   = cnt_next;
                fdone_d = fdone_next;
            end
            MODE_LOAD: begin
                // a load is never a shift, so it cannot complete a frame
                shreg_d = p_din;
                cnt_d   = '0;
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            shreg_q <= RESET_VAL;
            sout_q  <= 1'b0;
            cnt_q   <= '0;
            fdone_q <= 1'b0;
        end else begin
            shreg_q <= shreg_d;
            sout_q  <= sout_d;
            cnt_q   <= cnt_d;
            fdone_q <= fdone_d;
        end
    end

    assign p_dout     = shreg_q;
    assign s_dout     = sout_q;
    assign bit_cnt    = cnt_q;
    assign frame_done = fdone_q;

endmodule

// File: tb/tb_univ_shift_reg.sv
// Testbench for univ_shift_reg (WIDTH=8, RESET_VAL=8'hA5).
// Stimulus process drives one edge at a time and pushes the expected outputs.
// Monitor process pops and compares one entry after every clock edge.

module tb_univ_shift_reg;

    localparam int W  = 8;
    localparam int RV = 'hA5;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [1:0]   mode = 2'b00;
    logic         din = 1'b0;
    logic         rot = 1'b0;
    logic [W-1:0] p_din = '0;
    logic [W-1:0] p_dout;
    logic         s_dout;
    logic [3:0]   bit_cnt;
    logic         frame_done;

    univ_shift_reg #(.WIDTH(W), .RESET_VAL(8'hA5)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .mode       (mode),
        .din        (din),
        .rot        (rot),
        .p_din      (p_din),
        .p_dout     (p_dout),
        .s_dout     (s_dout),
        .bit_cnt    (bit_cnt),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int p;
        int s;
        int c;
        int f;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;

    // Reference model state (plain integers)
    int mv, ms, mc, mf;

    task automatic chk(input string nm, input int act, input int req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, req, $time);
        end
    endtask

    // Drive one edge worth of inputs and predict the outputs after that edge.
    task automatic step(input logic r, input logic [1:0] m, input logic d,
                        input logic ro, input logic [W-1:0] pd);
        int   ib;
        int   top;
        exp_t e;
        @(negedge clk);
        rst_n = r; mode = m; din = d; rot = ro; p_din = pd;
        top = 1 << (W - 1);
        if (!r) begin
            mv = RV; ms = 0; mc = 0; mf = 0;
        end else if (m == 2'b00) begin
            mf = 0;
        end else if (m == 2'b11) begin
            mv = int'(pd); mc = 0; mf = 0;
        end else begin
            ib = int'(d);
            if (m == 2'b01) begin
`ifdef USR_ROTATE_EN
                if (ro) ib = mv / top;
`endif
                ms = mv / top;
                mv = (mv * 2 + ib) % (1 << W);
            end else begin
`ifdef USR_ROTATE_EN
                if (ro) ib = mv % 2;
`endif
                ms = mv % 2;
                mv = mv / 2 + ib * top;
            end
            mc = mc + 1;
            if (mc == W) begin mc = 0; mf = 1; end
            else mf = 0;
        end
        e.p = mv; e.s = ms; e.c = mc; e.f = mf;
        exp_q.push_back(e);
    endtask

    // Wait until just after the edge of the most recent step, for directed checks.
    task automatic after_edge();
        @(posedge clk);
        #2;
    endtask

    // Monitor: every edge presents a new output word
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("p_dout",     int'(p_dout),     e.p);
                chk("s_dout",     int'(s_dout),     e.s);
                chk("bit_cnt",    int'(bit_cnt),    e.c);
                chk("frame_done", int'(frame_done), e.f);
            end
        end
    end

    initial begin
        logic [7:0] sipo_bits;
        logic [7:0] c3_bits;
        int         fd_seen;
        int         waited;
        sipo_bits = 8'b10110010;
        c3_bits   = 8'b11000011;

        // Reset for two edges with mode=shift left
        step(1'b0, 2'b01, 1'b1, 1'b0, 8'h00);
        step(1'b0, 2'b01, 1'b1, 1'b0, 8'h00);
        after_edge();
        chk("tp_reset_p", int'(p_dout), 'hA5);
        chk("tp_reset_f", int'(frame_done), 0);

        // Serial-to-parallel: MSB-first 1,0,1,1,0,0,1,0
        fd_seen = 0;
        for (int i = 7; i >= 0; i--) begin
            step(1'b1, 2'b01, sipo_bits[i], 1'b0, 8'h00);
            after_edge();
            if (frame_done) fd_seen++;
        end
        chk("tp_sipo_p", int'(p_dout), 'hB2);
        chk("tp_sipo_c", int'(bit_cnt), 0);
        chk("tp_sipo_f", int'(frame_done), 1);
        chk("tp_sipo_pulses", fd_seen, 1);
        step(1'b1, 2'b00, 1'b0, 1'b0, 8'h00);

        // Parallel-to-serial: load C3, shift right with din=0
        step(1'b1, 2'b11, 1'b0, 1'b0, 8'hC3);
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 2'b10, 1'b0, 1'b0, 8'h00);
            after_edge();
            chk("tp_piso_s", int'(s_dout), int'(c3_bits[i]));
        end
        chk("tp_piso_p", int'(p_dout), 0);
        chk("tp_piso_f", int'(frame_done), 1);

        // Shift 5, hold 3, shift 3
        for (int i = 0; i < 5; i++) step(1'b1, 2'b01, 1'($urandom_range(1)), 1'b0, 8'h00);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 2'b00, 1'b1, 1'b0, 8'h00);
            after_edge();
            chk("tp_hold_cnt", int'(bit_cnt), 5);
        end
        for (int i = 0; i < 3; i++) step(1'b1, 2'b10, 1'($urandom_range(1)), 1'b0, 8'h00);
        after_edge();
        chk("tp_resume_f", int'(frame_done), 1);

        // Shift 7 then reset, shift 7 then load: no frame_done
        for (int i = 0; i < 7; i++) step(1'b1, 2'b01, 1'b1, 1'b0, 8'h00);
        step(1'b0, 2'b01, 1'b1, 1'b0, 8'h00);
        after_edge();
        chk("tp_rst7_f", int'(frame_done), 0);
        for (int i = 0; i < 7; i++) step(1'b1, 2'b01, 1'b0, 1'b0, 8'h00);
        step(1'b1, 2'b11, 1'b0, 1'b0, 8'h5A);
        after_edge();
        chk("tp_load7_f", int'(frame_done), 0);
        chk("tp_load7_c", int'(bit_cnt), 0);

        // Rotate: load 81, shift left with rot=1, din=0
        step(1'b1, 2'b11, 1'b0, 1'b0, 8'h81);
        for (int i = 0; i < 8; i++) step(1'b1, 2'b01, 1'b0, 1'b1, 8'h00);
        after_edge();
`ifdef USR_ROTATE_EN
        chk("tp_rot_p", int'(p_dout), 'h81);
`else
        chk("tp_rot_p", int'(p_dout), 'h00);
`endif
        chk("tp_rot_f", int'(frame_done), 1);

        // Random traffic, mostly shifts, occasional load/hold/reset
        for (int i = 0; i < 400; i++) begin
            int sel;
            sel = int'($urandom_range(99));
            step((sel < 3) ? 1'b0 : 1'b1,
                 (sel < 70) ? 2'(1 + $urandom_range(1)) :
                 (sel < 85) ? 2'b00 : 2'b11,
                 1'($urandom_range(1)), 1'($urandom_range(1)), 8'($urandom));
        end

        waited = 0;
        while (exp_q.size() > 0 && waited < 10) begin
            @(posedge clk);
            waited++;
        end
        #2;
        checks++;
        if (exp_q.size() > 0) begin
            errors++;
            $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
